arm_hazard_unit: RTL and testbench

Pipeline interlock and forwarding controller between decode and execute. It consumes the decoded register-read set, destination and flag-write information for the instruction in decode. It tracks in-flight destinations in the EX, MEM and WB stages, and produces per-operand forwarding selects, a decode stall, and the drain-then-halt sequence for SWI.

---
 rtl/arm_hazard_unit_pkg.sv | 38 +++
 rtl/arm_hazard_unit_if.sv | 33 +++
 rtl/arm_hazard_unit_fwd_match.sv | 49 ++++
 rtl/arm_hazard_unit.sv | 109 ++++++++++
 tb/tb_arm_hazard_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/arm_hazard_unit_pkg.sv
// arm_pipe_pkg: shared types for the ARM pipeline hazard unit.
//   stage_rec_t   - per-stage destination/flag tracking record
//   hz_state_t    - interlock FSM states (RUN, DRAIN, HALTED)
//   FWD_*         - forwarding select encodings
//   stage_writes  - "this stage record will write register r"
package arm_pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic       rd_we;
    logic [3:0] rd_num;
    logic       is_load;
    logic       cpsr_we;
  } stage_rec_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    HALTED = ST_HALTED
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam stage_rec_t STAGE_BUBBLE = '{valid: 1'b0, rd_we: 1'b0, rd_num: 4'd0,
                                          is_load: 1'b0, cpsr_we: 1'b0};

  function automatic logic stage_writes(input stage_rec_t s, input logic [3:0] r);
    return s.valid & s.rd_we & (s.rd_num == r);
  endfunction

endpackage

// File: rtl/arm_hazard_unit_if.sv
// arm_hazard_unit_if: decode <-> hazard unit bundle.
//   master: decode stage (drives dcd_*, observes stall/fwd_sel/pipe_empty/halted)
//   slave : hazard unit
// dcd_read_reg packs slot i at [4*i +: 4]; fwd_sel packs slot i at [2*i +: 2].
interface arm_hazard_unit_if #(
  parameter int NUM_SRC = 3
);
  logic                   dcd_valid;
  logic [NUM_SRC-1:0]     dcd_read_mask;
  logic [NUM_SRC*4-1:0]   dcd_read_reg;
  logic                   dcd_rd_we;
  logic [3:0]             dcd_rd_num;
  logic                   dcd_is_load;
  logic                   dcd_cpsr_we;
  logic                   dcd_is_cond;
  logic                   dcd_halt;
  logic                   stall;
  logic [NUM_SRC*2-1:0]   fwd_sel;
  logic                   pipe_empty;
  logic                   halted;

  modport master (
    output dcd_valid, dcd_read_mask, dcd_read_reg, dcd_rd_we, dcd_rd_num,
           dcd_is_load, dcd_cpsr_we, dcd_is_cond, dcd_halt,
    input  stall, fwd_sel, pipe_empty, halted
  );

  modport slave (
    input  dcd_valid, dcd_read_mask, dcd_read_reg, dcd_rd_we, dcd_rd_num,
           dcd_is_load, dcd_cpsr_we, dcd_is_cond, dcd_halt,
    output stall, fwd_sel, pipe_empty, halted
  );
endinterface

// File: rtl/arm_hazard_unit_fwd_match.sv
// arm_fwd_match: one source slot compared against the EX/MEM/WB records.
//   rd_mask  in  slot is actually read
//   rd_reg   in  slot register number
//   ex/mem/wb in stage records
//   sel      out forwarding select, youngest producer first
//   load_hit out slot depends on a load still in EX (load-use)
module arm_fwd_match
  import arm_pipe_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       rd_mask,
  input  logic [3:0] rd_reg,
  input  stage_rec_t ex,
  input  stage_rec_t mem,
  input  stage_rec_t wb,
  output logic [1:0] sel,
  output logic       load_hit
);

  logic live_s;
  logic ex_hit_s;
  logic mem_hit_s;
  logic wb_hit_s;

  // PC reads never forward: fetch supplies the PC value.
  assign live_s    = rd_mask & (rd_reg != PC_REG);
  assign ex_hit_s  = live_s & stage_writes(ex, rd_reg);
  assign mem_hit_s = live_s & stage_writes(mem, rd_reg);
  assign wb_hit_s  = live_s & stage_writes(wb, rd_reg);

  // Priority select: youngest in-flight writer wins.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit_s) begin
      sel = FWD_EX;
    end else if (mem_hit_s) begin
      sel = FWD_MEM;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

  // A load in MEM is already post-memory, so only EX loads interlock.
  assign load_hit = ex_hit_s & ex.is_load;

endmodule

// File: rtl/arm_hazard_unit.sv
// arm_hazard_unit: decode/execute interlock and forwarding controller.
//   clk  in  single clock, rising edge
//   rst  in  synchronous active-high reset
//   hz   slave modport of arm_hazard_unit_if (decode inputs, stall,
//        fwd_sel, pipe_empty, halted)
// Tracks destinations in EX/MEM/WB, produces per-slot forwarding selects,
// a combinational decode stall, and the SWI drain-then-halt sequence.
module arm_hazard_unit
  import arm_pipe_pkg::*;
#(
  parameter int         NUM_SRC = 3,
  parameter logic [3:0] PC_REG  = 4'd15
) (
  input  logic            clk,
  input  logic            rst,
  arm_hazard_unit_if.slave hz
);

  stage_rec_t           ex_r;
  stage_rec_t           mem_r;
  stage_rec_t           wb_r;
  hz_state_t            state_r;
  hz_state_t            state_nxt_s;
  stage_rec_t           dcd_rec_s;
  logic [NUM_SRC*2-1:0] sel_s;
  logic [NUM_SRC-1:0]   load_hit_s;
  logic                 flag_busy_s;
  logic                 hazard_s;
  logic                 stall_s;
  logic                 accept_s;
  logic                 pipe_empty_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    arm_fwd_match #(.PC_REG(PC_REG)) u_match (
      .rd_mask  (hz.dcd_read_mask[i]),
      .rd_reg   (hz.dcd_read_reg[4*i +: 4]),
      .ex       (ex_r),
      .mem      (mem_r),
      .wb       (wb_r),
      .sel      (sel_s[2*i +: 2]),
      .load_hit (load_hit_s[i])
    );
  end

  // No CPSR forwarding: a conditional waits until every flag writer leaves WB.
  assign flag_busy_s = (ex_r.valid & ex_r.cpsr_we) | (mem_r.valid & mem_r.cpsr_we) |
                       (wb_r.valid & wb_r.cpsr_we);
  assign hazard_s    = (|load_hit_s) | (hz.dcd_is_cond & flag_busy_s);
  assign pipe_empty_s = ~(ex_r.valid | mem_r.valid | wb_r.valid);

  // Decode stall: hazard-driven in RUN, unconditional once SWI is accepted.
  always_comb begin
    stall_s = 1'b1;
    case (state_r)
      RUN:     stall_s = hz.dcd_valid & hazard_s;
      DRAIN:   stall_s = 1'b1;
      HALTED:  stall_s = 1'b1;
      default: stall_s = 1'b1;
    endcase
  end

  assign accept_s  = (state_r == RUN) & hz.dcd_valid & ~stall_s;
  assign dcd_rec_s = '{valid: 1'b1, rd_we: hz.dcd_rd_we, rd_num: hz.dcd_rd_num,
                       is_load: hz.dcd_is_load, cpsr_we: hz.dcd_cpsr_we};

  // FSM next state: SWI drains the pipe, then halts until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (accept_s & hz.dcd_halt) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HALTED:  state_nxt_s = HALTED;
      default: state_nxt_s = RUN;
    endcase
  end

  // Stage records advance every cycle; SWI itself enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r    <= STAGE_BUBBLE;
      mem_r   <= STAGE_BUBBLE;
      wb_r    <= STAGE_BUBBLE;
      state_r <= RUN;
    end else begin
      ex_r    <= (accept_s & ~hz.dcd_halt) ? dcd_rec_s : STAGE_BUBBLE;
      mem_r   <= ex_r;
      wb_r    <= mem_r;
      state_r <= state_nxt_s;
    end
  end

  assign hz.stall      = stall_s;
  assign hz.fwd_sel    = sel_s;
  assign hz.pipe_empty = pipe_empty_s;
  assign hz.halted     = (state_r == HALTED);

endmodule

// File: tb/tb_arm_hazard_unit.sv
// tb_arm_hazard_unit: directed self-checking bench for arm_hazard_unit.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_arm_hazard_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  arm_hazard_unit_if #(.NUM_SRC(3)) hz ();

  arm_hazard_unit #(.NUM_SRC(3), .PC_REG(4'd15)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one decode slot for the next cycle.
  task automatic dec(input logic v, input logic [2:0] m, input logic [3:0] r0,
                     input logic [3:0] r1, input logic [3:0] r2, input logic we,
                     input logic [3:0] rd, input logic ld, input logic cw,
                     input logic cond, input logic halt);
    @(negedge clk);
    hz.dcd_valid     = v;
    hz.dcd_read_mask = m;
    hz.dcd_read_reg  = {r2, r1, r0};
    hz.dcd_rd_we     = we;
    hz.dcd_rd_num    = rd;
    hz.dcd_is_load   = ld;
    hz.dcd_cpsr_we   = cw;
    hz.dcd_is_cond   = cond;
    hz.dcd_halt      = halt;
    #1;
  endtask

  task automatic idle();
    dec(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    idle(); idle(); idle();
  endtask

  // ADD rd, ra, rb (plain ALU writer, two reads)
  task automatic alu(input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    dec(1'b1, 3'b011, ra, rb, 4'd0, 1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    chk("rst_stall", {7'd0, hz.stall}, 8'd0);
    chk("rst_fwd", {2'd0, hz.fwd_sel}, 8'd0);
    chk("rst_empty", {7'd0, hz.pipe_empty}, 8'd1);
    chk("rst_halted", {7'd0, hz.halted}, 8'd0);

    // Forwarding distance: 0,1,2,3 bubbles between producer and consumer.
    alu(4'd1, 4'd2, 4'd3);
    chk("add_first_stall", {7'd0, hz.stall}, 8'd0);
    alu(4'd4, 4'd1, 4'd5);
    chk("fwd_ex", {2'd0, hz.fwd_sel}, 8'h01);
    chk("fwd_ex_stall", {7'd0, hz.stall}, 8'd0);
    flush();
    alu(4'd1, 4'd2, 4'd3);
    idle();
    alu(4'd4, 4'd1, 4'd5);
    chk("fwd_mem", {2'd0, hz.fwd_sel}, 8'h02);
    flush();
    alu(4'd1, 4'd2, 4'd3);
    idle(); idle();
    alu(4'd4, 4'd1, 4'd5);
    chk("fwd_wb", {2'd0, hz.fwd_sel}, 8'h03);
    flush();
    alu(4'd1, 4'd2, 4'd3);
    idle(); idle(); idle();
    alu(4'd4, 4'd1, 4'd5);
    chk("fwd_rf", {2'd0, hz.fwd_sel}, 8'h00);
    flush();

    // Load-use: one stall, then both slots take the MEM result.
    dec(1'b1, 3'b001, 4'd2, 4'd0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    alu(4'd3, 4'd1, 4'd1);
    chk("lu_stall", {7'd0, hz.stall}, 8'd1);
    alu(4'd3, 4'd1, 4'd1);
    chk("lu_release", {7'd0, hz.stall}, 8'd0);
    chk("lu_fwd_mem", {2'd0, hz.fwd_sel}, 8'h0A);
    flush();

    // Flag hazard: MOVS then conditional waits three cycles.
    dec(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    dec(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flag_c1", {7'd0, hz.stall}, 8'd1);
    dec(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flag_c2", {7'd0, hz.stall}, 8'd1);
    dec(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flag_c3", {7'd0, hz.stall}, 8'd1);
    dec(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flag_release", {7'd0, hz.stall}, 8'd0);
    flush();

    // r15 never forwards nor interlocks, even behind a load to r15.
    dec(1'b1, 3'b001, 4'd2, 4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    dec(1'b1, 3'b011, 4'd15, 4'd15, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc_fwd", {2'd0, hz.fwd_sel}, 8'h00);
    chk("pc_stall", {7'd0, hz.stall}, 8'd0);
    flush();

    // Masked slot with a matching register is ignored.
    dec(1'b1, 3'b001, 4'd2, 4'd0, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    dec(1'b1, 3'b010, 4'd7, 4'd8, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mask_fwd", {2'd0, hz.fwd_sel}, 8'h00);
    chk("mask_stall", {7'd0, hz.stall}, 8'd0);
    flush();

    // Same destination in EX and MEM: EX wins.
    alu(4'd5, 4'd2, 4'd3);
    alu(4'd5, 4'd2, 4'd3);
    dec(1'b1, 3'b001, 4'd5, 4'd0, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ex_wins", {2'd0, hz.fwd_sel}, 8'h01);
    flush();

    // MLA r1,r2,r3,r4: r4 in WB, r2 in EX, r3 from the register file.
    alu(4'd4, 4'd8, 4'd9);
    idle();
    alu(4'd2, 4'd8, 4'd9);
    dec(1'b1, 3'b111, 4'd4, 4'd2, 4'd3, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mla_fwd", {2'd0, hz.fwd_sel}, 8'h07);
    chk("mla_stall", {7'd0, hz.stall}, 8'd0);
    flush();

    // SWI after ADD r1: drain, halt within 4 cycles, hold, then reset.
    alu(4'd1, 4'd2, 4'd3);
    dec(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("swi_accept", {7'd0, hz.stall}, 8'd0);
    alu(4'd6, 4'd2, 4'd3);
    chk("drain1_stall", {7'd0, hz.stall}, 8'd1);
    chk("drain1_empty", {7'd0, hz.pipe_empty}, 8'd0);
    alu(4'd6, 4'd2, 4'd3);
    chk("drain2_empty", {7'd0, hz.pipe_empty}, 8'd0);
    alu(4'd6, 4'd2, 4'd3);
    chk("drain3_empty", {7'd0, hz.pipe_empty}, 8'd1);
    chk("drain3_halted", {7'd0, hz.halted}, 8'd0);
    chk("drain3_stall", {7'd0, hz.stall}, 8'd1);
    alu(4'd6, 4'd2, 4'd3);
    chk("halt_n4", {7'd0, hz.halted}, 8'd1);
    alu(4'd6, 4'd2, 4'd3);
    chk("halt_hold", {7'd0, hz.halted}, 8'd1);
    chk("halt_stall", {7'd0, hz.stall}, 8'd1);
    chk("halt_empty", {7'd0, hz.pipe_empty}, 8'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();
    chk("rerst_halted", {7'd0, hz.halted}, 8'd0);
    chk("rerst_empty", {7'd0, hz.pipe_empty}, 8'd1);
    alu(4'd1, 4'd2, 4'd3);
    chk("rerst_run", {7'd0, hz.stall}, 8'd0);
    alu(4'd4, 4'd1, 4'd5);
    chk("rerst_fwd", {2'd0, hz.fwd_sel}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
